// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and helpers for the byte-serial RAM arbiter
// Purpose: FSM state encoding, round-robin mode constants, drive-level
//          enable/disable constants and the transfer-length clamp helper.
// Ports:   none (package)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  localparam int RR_FIXED = 0;
  localparam int RR_ROUND = 1;

  localparam bit ARB_ENABLE  = 1'b1;
  localparam bit ARB_DISABLE = 1'b0;

  localparam int LEN_W = 3;

  // len is encoded as bytes-1; anything past the last byte lane is clamped to it.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len, input int nb);
    if (int'(len) >= nb) return LEN_W'(nb - 1);
    return len;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - combinational winner selection among NUM_CH requesters
// Purpose: picks one requester from req_i & ~mask_i, either highest index
//          (rr_i = 0) or first found searching upward from ptr_i (rr_i = 1).
// Ports:   req_i  - request vector        mask_i - channels excluded this cycle
//          ptr_i  - round-robin start     rr_i   - 1 = round-robin search
//          gnt_o  - one-hot grant         idx_o  - grant index
//          hit_o  - some channel eligible
module arb_pick #(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [NUM_CH-1:0] mask_i,
  input  logic [IDX_W-1:0]  ptr_i,
  input  logic              rr_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              hit_o
);
  import mem_arb_pkg::*;

  logic [NUM_CH-1:0] eligible;
  logic [IDX_W:0]    cand;

  assign eligible = req_i & ~mask_i;

  always_comb begin
    idx_o = '0;
    hit_o = 1'b0;
    cand  = '0;
    if (rr_i) begin
      // Walk ptr, ptr+1, ... wrapping at NUM_CH; the first eligible one wins.
      for (int i = 0; i < NUM_CH; i++) begin
        cand = {1'b0, ptr_i} + (IDX_W+1)'(i);
        if (cand >= (IDX_W+1)'(NUM_CH)) cand = cand - (IDX_W+1)'(NUM_CH);
        if (!hit_o && eligible[cand[IDX_W-1:0]]) begin
          hit_o = 1'b1;
          idx_o = cand[IDX_W-1:0];
        end
      end
    end else begin
      // Later iterations overwrite, so the highest eligible index wins.
      for (int i = 0; i < NUM_CH; i++) begin
        if (eligible[i]) begin
          hit_o = 1'b1;
          idx_o = IDX_W'(i);
        end
      end
    end
  end

  assign gnt_o = hit_o ? (NUM_CH'(1) << idx_o) : '0;

endmodule

// File: rtl/ram_arbiter_seq.sv
// rtl/ram_arbiter_seq.sv - arbitrates NUM_CH requesters onto a byte-wide RAM port
// Purpose: grants one request at a time, serialises 1..DATA_W/8 little-endian
//          bytes onto the RAM, absorbs the 1-cycle read latency and returns
//          assembled read data with a one-cycle done pulse.
// Ports:   clk, rst (async, active low)
//          req_i/we_i/len_i/addr_i/wdata_i - per-channel request fields
//          done_o  - completion pulse      stall_o - req_i & ~done_o
//          rdata_o - read result, valid with done_o
//          ram_a_o/ram_dout_o/ram_wr_o/ram_din_i - RAM port
module ram_arbiter_seq #(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RR_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req_i,
  input  logic [NUM_CH-1:0]        we_i,
  input  logic [NUM_CH*3-1:0]      len_i,
  input  logic [NUM_CH*ADDR_W-1:0] addr_i,
  input  logic [NUM_CH*DATA_W-1:0] wdata_i,
  output logic [NUM_CH-1:0]        done_o,
  output logic [NUM_CH-1:0]        stall_o,
  output logic [DATA_W-1:0]        rdata_o,
  output logic [ADDR_W-1:0]        ram_a_o,
  output logic [7:0]               ram_dout_o,
  output logic                     ram_wr_o,
  input  logic [7:0]               ram_din_i
);
  import mem_arb_pkg::*;

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = $clog2(NUM_CH);

  arb_state_e        state_q;
  logic [NUM_CH-1:0] owner_oh_q;
  logic [NUM_CH-1:0] done_q;
  logic [IDX_W-1:0]  ptr_q;
  logic              we_q;
  logic [2:0]        len_q;
  logic [2:0]        cnt_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] ram_a_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] asm_q;
  logic [DATA_W-1:0] rdata_q;
  logic [7:0]        ram_dout_q;
  logic              ram_wr_q;

  logic [NUM_CH-1:0] pick_gnt;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_hit;
  logic              arb_en;

  logic              sel_we;
  logic [2:0]        sel_len;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic [2:0]        cnt_d;
  logic [ADDR_W-1:0] addr_d;
  logic [7:0]        wbyte_d;
  logic              cap_en;
  logic [2:0]        cap_idx;
  logic [DATA_W-1:0] asm_d;

  // The finishing owner is masked during DONE so a different channel can be
  // granted in the same cycle without the owner re-winning immediately.
  arb_pick #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_pick (
    .req_i  (req_i),
    .mask_i (done_q),
    .ptr_i  (ptr_q),
    .rr_i   (RR_MODE == RR_ROUND),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .hit_o  (pick_hit)
  );

  assign arb_en    = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign sel_we    = we_i[pick_idx];
  assign sel_len   = clamp_len(len_i[pick_idx*3 +: 3], NB);
  assign sel_addr  = addr_i[pick_idx*ADDR_W +: ADDR_W];
  assign sel_wdata = wdata_i[pick_idx*DATA_W +: DATA_W];

  assign cnt_d   = cnt_q + 3'd1;
  assign addr_d  = base_q + ADDR_W'(cnt_d);
  assign wbyte_d = 8'(wdata_q >> {cnt_d, 3'b000});

  // Read data trails its address by one cycle: in XFER byte k-1 arrives while
  // byte k is addressed, and the last byte arrives in DRAIN.
  assign cap_en  = !we_q && (((state_q == ST_XFER) && (cnt_q != 3'd0)) || (state_q == ST_DRAIN));
  assign cap_idx = (state_q == ST_DRAIN) ? len_q : (cnt_q - 3'd1);

  always_comb begin
    asm_d = asm_q;
    for (int b = 0; b < NB; b++) begin
      if (cap_en && (cap_idx == 3'(b))) asm_d[8*b +: 8] = ram_din_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      owner_oh_q <= '0;
      done_q     <= '0;
      ptr_q      <= '0;
      we_q       <= 1'b0;
      len_q      <= '0;
      cnt_q      <= '0;
      base_q     <= '0;
      ram_a_q    <= '0;
      wdata_q    <= '0;
      asm_q      <= '0;
      rdata_q    <= '0;
      ram_dout_q <= '0;
      ram_wr_q   <= ARB_DISABLE;
    end else begin
      done_q  <= '0;
      rdata_q <= '0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (arb_en && pick_hit) begin
            owner_oh_q <= pick_gnt;
            we_q       <= sel_we;
            len_q      <= sel_len;
            base_q     <= sel_addr;
            wdata_q    <= sel_wdata;
            cnt_q      <= '0;
            asm_q      <= '0;
            ram_a_q    <= sel_addr;
            ram_dout_q <= sel_wdata[7:0];
            ram_wr_q   <= sel_we;
            if (RR_MODE == RR_ROUND) begin
              ptr_q <= (pick_idx == IDX_W'(NUM_CH - 1)) ? '0 : pick_idx + 1'b1;
            end
            state_q <= ST_XFER;
          end else begin
            ram_wr_q <= ARB_DISABLE;
            state_q  <= ST_IDLE;
          end
        end
        ST_XFER: begin
          asm_q <= asm_d;
          if (cnt_q == len_q) begin
            ram_wr_q <= ARB_DISABLE;
            if (we_q) begin
              done_q  <= owner_oh_q;
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_DRAIN;
            end
          end else begin
            cnt_q      <= cnt_d;
            ram_a_q    <= addr_d;
            ram_dout_q <= wbyte_d;
          end
        end
        ST_DRAIN: begin
          asm_q    <= asm_d;
          rdata_q  <= asm_d;
          done_q   <= owner_oh_q;
          ram_wr_q <= ARB_DISABLE;
          state_q  <= ST_DONE;
        end
        default: begin
          ram_wr_q <= ARB_DISABLE;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign done_o     = done_q;
  assign stall_o    = req_i & ~done_q;
  assign rdata_o    = rdata_q;
  assign ram_a_o    = ram_a_q;
  assign ram_dout_o = ram_dout_q;
  assign ram_wr_o   = ram_wr_q;

endmodule

// File: tb/tb_ram_arbiter_seq.sv
// tb/tb_ram_arbiter_seq.sv - self-checking bench for ram_arbiter_seq
module tb_ram_arbiter_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // DUT A: 2 channels, fixed priority, with a 256-byte RAM model.
  logic [1:0]  req_a, we_a, done_a, stall_a;
  logic [5:0]  len_a;
  logic [63:0] addr_a, wdata_a;
  logic [31:0] rdata_a, ram_a_a;
  logic [7:0]  ram_dout_a, ram_din_a;
  logic        ram_wr_a;

  // DUT B: 3 channels, round-robin, write-only traffic.
  logic [2:0]  req_b, we_b, done_b, stall_b;
  logic [8:0]  len_b;
  logic [95:0] addr_b, wdata_b;
  logic [31:0] rdata_b, ram_a_b;
  logic [7:0]  ram_dout_b, ram_din_b;
  logic        ram_wr_b;

  ram_arbiter_seq #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .RR_MODE(0)) dut_a (
    .clk(clk), .rst(rst), .req_i(req_a), .we_i(we_a), .len_i(len_a), .addr_i(addr_a),
    .wdata_i(wdata_a), .done_o(done_a), .stall_o(stall_a), .rdata_o(rdata_a),
    .ram_a_o(ram_a_a), .ram_dout_o(ram_dout_a), .ram_wr_o(ram_wr_a), .ram_din_i(ram_din_a)
  );

  ram_arbiter_seq #(.NUM_CH(3), .ADDR_W(32), .DATA_W(32), .RR_MODE(1)) dut_b (
    .clk(clk), .rst(rst), .req_i(req_b), .we_i(we_b), .len_i(len_b), .addr_i(addr_b),
    .wdata_i(wdata_b), .done_o(done_b), .stall_o(stall_b), .rdata_o(rdata_b),
    .ram_a_o(ram_a_b), .ram_dout_o(ram_dout_b), .ram_wr_o(ram_wr_b), .ram_din_i(ram_din_b)
  );

  logic [7:0] mem_a [256];
  logic [7:0] ref_mem [256];
  logic       pl_en;
  logic [7:0] pl_addr, pl_data;

  always @(posedge clk) begin
    ram_din_a <= mem_a[ram_a_a[7:0]];
    if (pl_en) mem_a[pl_addr] <= pl_data;
    else if (ram_wr_a) mem_a[ram_a_a[7:0]] <= ram_dout_a;
  end

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] rec_a [20];
  logic        rec_wr [20];
  logic [7:0]  rec_dout [20];

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    ref_mem[a] = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Issues one request on DUT A and records the RAM bus per cycle (cycle 0 = first cycle req is seen).
  task automatic drive_a(input int ch, input bit we, input logic [2:0] len, input logic [31:0] addr,
                         input logic [31:0] wd, output int dcyc, output logic [31:0] rd);
    @(posedge clk); #1;
    req_a[ch] = 1'b1; we_a[ch] = we; len_a[ch*3 +: 3] = len;
    addr_a[ch*32 +: 32] = addr; wdata_a[ch*32 +: 32] = wd;
    dcyc = -1; rd = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      rec_a[c] = ram_a_a; rec_wr[c] = ram_wr_a; rec_dout[c] = ram_dout_a;
      if (done_a[ch]) begin
        dcyc = c; rd = rdata_a;
        break;
      end
    end
    req_a[ch] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (ram_wr_a !== 1'b0) begin n_fail++; $display("FAIL reset_wr actual=%b expected=0", ram_wr_a); end
    n_checks++; if (ram_a_a !== 32'h0) begin n_fail++; $display("FAIL reset_addr actual=%h expected=0", ram_a_a); end
    n_checks++; if (ram_dout_a !== 8'h0) begin n_fail++; $display("FAIL reset_dout actual=%h expected=0", ram_dout_a); end
    n_checks++; if (rdata_a !== 32'h0) begin n_fail++; $display("FAIL reset_rdata actual=%h expected=0", rdata_a); end
    n_checks++; if ({done_a, done_b} !== 5'b0) begin n_fail++; $display("FAIL reset_done actual=%b expected=0", {done_a, done_b}); end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_read_basic();
    int dcyc; logic [31:0] rd; bit ok;
    preload(8'h00, 8'h11); preload(8'h01, 8'h22); preload(8'h02, 8'h33); preload(8'h03, 8'h44);
    drive_a(0, 1'b0, 3'd3, 32'h1000, 32'h0, dcyc, rd);
    ok = 1'b1;
    for (int k = 0; k < 4; k++) if (rec_a[k+1] !== 32'h1000 + k || rec_wr[k+1] !== 1'b0) ok = 1'b0;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL read_addr_seq actual=%h..%h expected=00001000..00001003", rec_a[1], rec_a[4]); end
    n_checks++; if (dcyc != 6) begin n_fail++; $display("FAIL read_latency actual=%0d expected=6", dcyc); end
    n_checks++; if (rd !== 32'h44332211) begin n_fail++; $display("FAIL read_data actual=%h expected=44332211", rd); end
  endtask

  task automatic test_write_basic();
    int dcyc; logic [31:0] rd;
    drive_a(1, 1'b1, 3'd1, 32'h2000, 32'h0000BEEF, dcyc, rd);
    n_checks++;
    if ({rec_wr[1], rec_dout[1], rec_a[1]} !== {1'b1, 8'hEF, 32'h2000}) begin
      n_fail++; $display("FAIL write_byte0 actual=%b/%h/%h expected=1/ef/00002000", rec_wr[1], rec_dout[1], rec_a[1]);
    end
    n_checks++;
    if ({rec_wr[2], rec_dout[2], rec_a[2]} !== {1'b1, 8'hBE, 32'h2001}) begin
      n_fail++; $display("FAIL write_byte1 actual=%b/%h/%h expected=1/be/00002001", rec_wr[2], rec_dout[2], rec_a[2]);
    end
    n_checks++; if (dcyc != 3) begin n_fail++; $display("FAIL write_latency actual=%0d expected=3", dcyc); end
    n_checks++; if (rec_wr[3] !== 1'b0) begin n_fail++; $display("FAIL write_wr_done actual=%b expected=0", rec_wr[3]); end
  endtask

  task automatic test_priority();
    int d0, d1; bit stall_ok;
    @(posedge clk); #1;
    req_a = 2'b11; we_a = 2'b11; len_a = {3'd1, 3'd0};
    addr_a = {32'h2100, 32'h3000}; wdata_a = {32'h1234, 32'h5A};
    d0 = -1; d1 = -1; stall_ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      rec_a[c] = ram_a_a; rec_wr[c] = ram_wr_a; rec_dout[c] = ram_dout_a;
      if (c <= 4 && stall_a[0] !== 1'b1) stall_ok = 1'b0;
      if (done_a[1]) begin d1 = c; req_a[1] = 1'b0; end
      if (done_a[0]) begin d0 = c; req_a[0] = 1'b0; break; end
    end
    req_a = 2'b00;
    n_checks++; if (rec_a[1] !== 32'h2100) begin n_fail++; $display("FAIL prio_first actual=%h expected=00002100", rec_a[1]); end
    n_checks++; if (d1 != 3) begin n_fail++; $display("FAIL prio_done1 actual=%0d expected=3", d1); end
    n_checks++;
    if ({rec_wr[4], rec_dout[4], rec_a[4]} !== {1'b1, 8'h5A, 32'h3000}) begin
      n_fail++; $display("FAIL prio_ch0_start actual=%b/%h/%h expected=1/5a/00003000", rec_wr[4], rec_dout[4], rec_a[4]);
    end
    n_checks++; if (d0 != 5) begin n_fail++; $display("FAIL prio_done0 actual=%0d expected=5", d0); end
    n_checks++; if (!stall_ok) begin n_fail++; $display("FAIL prio_stall0 actual=0 expected=1"); end
  endtask

  task automatic test_rr();
    int got[$]; int exp_ch;
    @(posedge clk); #1;
    req_b = 3'b111; we_b = 3'b111; len_b = '0;
    addr_b = {32'h300, 32'h200, 32'h100}; wdata_b = {32'hC3, 32'hB2, 32'hA1};
    for (int c = 0; c < 40 && got.size() < 4; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) if (done_b[i]) got.push_back(i);
    end
    req_b = 3'b000;
    n_checks++; if (got.size() != 4) begin n_fail++; $display("FAIL rr_count actual=%0d expected=4", got.size()); end
    // With everyone requesting, each grant goes to the channel after the one just served.
    exp_ch = 0;
    for (int i = 0; i < got.size(); i++) begin
      n_checks++; if (got[i] != exp_ch) begin n_fail++; $display("FAIL rr_order[%0d] actual=%0d expected=%0d", i, got[i], exp_ch); end
      exp_ch = (exp_ch + 1) % 3;
    end
  endtask

  task automatic test_wrap();
    int dcyc; logic [31:0] rd; logic [7:0] b0, b1;
    b0 = 8'($urandom); b1 = 8'($urandom);
    preload(8'hFF, b0); preload(8'h00, b1);
    drive_a(0, 1'b0, 3'd1, 32'hFFFFFFFF, 32'h0, dcyc, rd);
    n_checks++;
    if (rec_a[1] !== 32'hFFFFFFFF || rec_a[2] !== 32'h0) begin
      n_fail++; $display("FAIL wrap_addr actual=%h,%h expected=ffffffff,00000000", rec_a[1], rec_a[2]);
    end
    n_checks++; if (rd !== {16'h0, b1, b0}) begin n_fail++; $display("FAIL wrap_data actual=%h expected=%h", rd, {16'h0, b1, b0}); end
    n_checks++; if (dcyc != 4) begin n_fail++; $display("FAIL wrap_latency actual=%0d expected=4", dcyc); end
  endtask

  task automatic test_reset_mid();
    int dcyc; logic [31:0] rd;
    preload(8'h40, 8'h00); preload(8'h41, 8'h00); preload(8'h42, 8'h00);
    @(posedge clk); #1;
    req_a[1] = 1'b1; we_a[1] = 1'b1; len_a[5:3] = 3'd3; addr_a[63:32] = 32'h40; wdata_a[63:32] = 32'hA1B2C3D4;
    repeat (4) @(negedge clk);
    n_checks++;
    if (ram_wr_a !== 1'b1 || ram_a_a !== 32'h42) begin
      n_fail++; $display("FAIL rstmid_byte2 actual=%b/%h expected=1/00000042", ram_wr_a, ram_a_a);
    end
    #1 rst = 1'b0;
    #1;
    n_checks++; if (ram_wr_a !== 1'b0) begin n_fail++; $display("FAIL rstmid_wr actual=%b expected=0", ram_wr_a); end
    req_a = 2'b00; we_a = 2'b00;
    @(posedge clk); #1;
    n_checks++;
    if ({mem_a[8'h40], mem_a[8'h41], mem_a[8'h42]} !== 24'hD4C300) begin
      n_fail++; $display("FAIL rstmid_partial actual=%h%h%h expected=d4c300", mem_a[8'h40], mem_a[8'h41], mem_a[8'h42]);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    drive_a(0, 1'b1, 3'd0, 32'h44, 32'h77, dcyc, rd);
    n_checks++; if (dcyc != 2) begin n_fail++; $display("FAIL rstmid_after actual=%0d expected=2", dcyc); end
  endtask

  task automatic test_random();
    int dcyc, ch, nb, exp_cyc; bit we, ok; logic [2:0] len;
    logic [31:0] addr, wd, rd, exp_rd, tmp;
    for (int a = 0; a < 256; a++) preload(8'(a), 8'($urandom));
    for (int t = 0; t < 30; t++) begin
      ch = $urandom_range(0, 1); we = 1'($urandom_range(0, 1)); len = 3'($urandom_range(0, 7));
      addr = $urandom; wd = $urandom;
      nb = (len > 3'd3) ? 4 : int'(len) + 1;
      exp_cyc = we ? nb + 1 : nb + 2;
      exp_rd = '0;
      if (!we) for (int k = 0; k < nb; k++) exp_rd[8*k +: 8] = ref_mem[8'(addr + 32'(k))];
      drive_a(ch, we, len, addr, wd, dcyc, rd);
      n_checks++; if (dcyc != exp_cyc) begin n_fail++; $display("FAIL rand_latency[%0d] actual=%0d expected=%0d", t, dcyc, exp_cyc); end
      ok = 1'b1;
      for (int k = 0; k < nb; k++) begin
        tmp = wd >> (8 * k);
        if (rec_a[k+1] !== addr + 32'(k) || rec_wr[k+1] !== we) ok = 1'b0;
        if (we && rec_dout[k+1] !== tmp[7:0]) ok = 1'b0;
      end
      if (rec_wr[nb+1] !== 1'b0) ok = 1'b0;
      n_checks++; if (!ok) begin n_fail++; $display("FAIL rand_bus[%0d] actual=first_addr %h expected=%h", t, rec_a[1], addr); end
      if (we) begin
        for (int k = 0; k < nb; k++) begin
          tmp = wd >> (8 * k);
          ref_mem[8'(addr + 32'(k))] = tmp[7:0];
        end
      end else begin
        n_checks++; if (rd !== exp_rd) begin n_fail++; $display("FAIL rand_rdata[%0d] actual=%h expected=%h", t, rd, exp_rd); end
      end
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        n_checks++; if (ram_wr_a !== 1'b0) begin n_fail++; $display("FAIL rand_idle_wr[%0d] actual=%b expected=0", t, ram_wr_a); end
      end
    end
    ok = 1'b1;
    for (int a = 0; a < 256; a++) if (mem_a[a] !== ref_mem[a]) ok = 1'b0;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rand_mem_image actual=differs expected=model"); end
  endtask

  initial begin
    rst = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    req_a = '0; we_a = '0; len_a = '0; addr_a = '0; wdata_a = '0;
    req_b = '0; we_b = '0; len_b = '0; addr_b = '0; wdata_b = '0; ram_din_b = '0;
    test_reset();
    test_read_basic();
    test_write_basic();
    test_priority();
    test_rr();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
